// File: rtl/axi_lite_port_arbiter.sv
// Shares one AXI4-Lite master between an instruction-fetch port and a data port.
// Only one AXI transaction is in flight at a time across both ports.
module axi_lite_port_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_data,
    output logic        i_rsp_err,

    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_wstrb,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,

    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_AR,
        RD_R,
        WR_AW_W,
        WR_B
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t state;
    port_t  owner;
    port_t  last_grant;

    logic grant_i;
    logic grant_d;
    logic i_accept;
    logic d_accept;
    logic aw_done;
    logic w_done;
    logic unused_resp_lsb;

    // NOTE: defaults first so no path through this block leaves a grant unassigned (no latch).
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (d_req_valid && (!i_req_valid || !RR_ENABLE || last_grant == PORT_I)) begin
            grant_d = 1'b1;
        end else if (i_req_valid) begin
            grant_i = 1'b1;
        end
    end

    // Ready is combinational so a request can be taken in the same IDLE cycle;
    // gating with reset_n keeps it low while reset is held.
    assign i_req_ready = reset_n && (state == IDLE) && grant_i;
    assign d_req_ready = reset_n && (state == IDLE) && grant_d;
    assign i_accept    = i_req_valid && i_req_ready;
    assign d_accept    = d_req_valid && d_req_ready;

    // A write channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !m_axi_awvalid || m_axi_awready;
    assign w_done  = !m_axi_wvalid || m_axi_wready;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    assign unused_resp_lsb = m_axi_rresp[0] ^ m_axi_bresp[0];

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner         <= PORT_I;
            last_grant    <= PORT_I;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            i_rsp_valid   <= 1'b0;
            i_rsp_data    <= '0;
            i_rsp_err     <= 1'b0;
            d_rsp_valid   <= 1'b0;
            d_rsp_rdata   <= '0;
            d_rsp_err     <= 1'b0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (d_accept) begin
                        owner      <= PORT_D;
                        last_grant <= PORT_D;
                        if (d_req_we) begin
                            m_axi_awaddr  <= d_req_addr;
                            m_axi_wdata   <= d_req_wdata;
                            m_axi_wstrb   <= d_req_wstrb;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_AW_W;
                        end else begin
                            m_axi_araddr  <= d_req_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_AR;
                        end
                    end else if (i_accept) begin
                        owner         <= PORT_I;
                        last_grant    <= PORT_I;
                        m_axi_araddr  <= i_req_addr;
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_AR;
                    end
                end

                RD_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_R;
                    end
                end

                RD_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        state        <= IDLE;
                        if (owner == PORT_D) begin
                            d_rsp_valid <= 1'b1;
                            d_rsp_rdata <= m_axi_rdata;
                            d_rsp_err   <= m_axi_rresp[1];
                        end else begin
                            i_rsp_valid <= 1'b1;
                            i_rsp_data  <= m_axi_rdata;
                            i_rsp_err   <= m_axi_rresp[1];
                        end
                    end
                end

                WR_AW_W: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_B;
                    end
                end

                WR_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        d_rsp_valid  <= 1'b1;
                        d_rsp_rdata  <= '0;
                        d_rsp_err    <= m_axi_bresp[1];
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_port_arbiter.sv
// Self-checking bench: transaction-level model of both requesters, a randomised AXI
// slave, and a second fixed-priority instance driven with permanent contention.
`timescale 1ns/1ps
module tb_axi_lite_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // Round-robin instance
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [3:0]  d_req_wstrb;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    // Fixed-priority instance
    logic        f_i_req_ready, f_i_rsp_valid, f_i_rsp_err;
    logic [31:0] f_i_rsp_data;
    logic        f_d_req_ready, f_d_rsp_valid, f_d_rsp_err;
    logic [31:0] f_d_rsp_rdata;
    logic [31:0] f_awaddr, f_wdata, f_araddr;
    logic [2:0]  f_awprot, f_arprot;
    logic [3:0]  f_wstrb;
    logic        f_awvalid, f_wvalid, f_bready, f_arvalid, f_rready;
    logic        f_rvalid = 1'b0;

    axi_lite_port_arbiter #(.RR_ENABLE(1'b1)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    axi_lite_port_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(1'b1), .i_req_addr(32'h0000_1000), .i_req_ready(f_i_req_ready),
        .i_rsp_valid(f_i_rsp_valid), .i_rsp_data(f_i_rsp_data), .i_rsp_err(f_i_rsp_err),
        .d_req_valid(1'b1), .d_req_we(1'b0), .d_req_addr(32'h0000_2000),
        .d_req_wdata(32'h0), .d_req_wstrb(4'h0), .d_req_ready(f_d_req_ready),
        .d_rsp_valid(f_d_rsp_valid), .d_rsp_rdata(f_d_rsp_rdata), .d_rsp_err(f_d_rsp_err),
        .m_axi_awaddr(f_awaddr), .m_axi_awprot(f_awprot), .m_axi_awvalid(f_awvalid),
        .m_axi_awready(1'b0), .m_axi_wdata(f_wdata), .m_axi_wstrb(f_wstrb),
        .m_axi_wvalid(f_wvalid), .m_axi_wready(1'b0), .m_axi_bresp(2'b00),
        .m_axi_bvalid(1'b0), .m_axi_bready(f_bready), .m_axi_araddr(f_araddr),
        .m_axi_arprot(f_arprot), .m_axi_arvalid(f_arvalid), .m_axi_arready(1'b1),
        .m_axi_rdata(32'h0000_00AA), .m_axi_rresp(2'b00), .m_axi_rvalid(f_rvalid),
        .m_axi_rready(f_rready)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending requests per port, the one transaction in flight,
    // its AXI channel progress, and the response owed on the next cycle.
    req_t i_q[$];
    req_t d_q[$];
    req_t cur;
    bit   i_hold, d_hold, busy, own_d, last_d;
    bit   ar_done, aw_done, w_done;
    bit   rsp_exp, rsp_exp_d, rsp_exp_err;
    logic [31:0] rsp_exp_data;
    int   ar_wait, r_wait, aw_wait, w_wait, b_wait;
    int   cfg_ar, cfg_r, cfg_aw, cfg_w, cfg_b, cfg_err, pres;
    bit   fix_rdata_en;
    logic [31:0] fix_rdata;
    bit   grants[$];
    int   i_pulses, d_pulses, cyc;

    function automatic int pick(input int c);
        return (c < 0) ? int'($urandom_range(3, 0)) : c;
    endfunction

    function automatic bit pick_err();
        return (cfg_err < 0) ? 1'($urandom_range(1, 0)) : cfg_err[0];
    endfunction

    function automatic req_t rd_req(input logic [31:0] addr);
        req_t r;
        r = '0;
        r.addr = addr;
        return r;
    endfunction

    function automatic req_t rand_req(input bit is_d);
        req_t r;
        r.we    = is_d ? 1'($urandom_range(1, 0)) : 1'b0;
        r.addr  = {$urandom_range(32'h3fff_ffff, 0), 2'b00};
        r.wdata = $urandom;
        r.wstrb = 4'($urandom_range(15, 0));
        return r;
    endfunction

    task automatic set_cfg(input int ar, input int r, input int aw, input int w, input int b,
                           input int err, input int p);
        cfg_ar = ar; cfg_r = r; cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_err = err; pres = p;
        fix_rdata_en = 1'b0;
    endtask

    task automatic clear_model();
        i_q.delete(); d_q.delete(); grants.delete();
        i_hold = 0; d_hold = 0; busy = 0; own_d = 0; last_d = 0;
        ar_done = 0; aw_done = 0; w_done = 0; rsp_exp = 0;
        cur = '0;
    endtask

    task automatic zero_inputs();
        i_req_valid = 0; i_req_addr = '0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_wstrb = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 32'(|{i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
                         d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
                         m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
                         m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
                         f_arvalid, f_rready, f_d_rsp_valid, f_i_rsp_valid}), 32'h0);
    endtask

    // Asserts reset at the current time, checks outputs asynchronously, releases on a negedge.
    task automatic apply_reset(input string tag);
        reset_n = 1'b0;
        zero_inputs();
        clear_model();
        #1;
        check_all_zero(tag);
        repeat (2) @(negedge clk);
        check_all_zero({tag, "_held"});
        reset_n = 1'b1;
    endtask

    task automatic accept(input bit is_d);
        cur = is_d ? d_q.pop_front() : i_q.pop_front();
        if (is_d) d_hold = 0; else i_hold = 0;
        busy = 1; own_d = is_d; last_d = is_d;
        grants.push_back(is_d);
        ar_done = 0; aw_done = 0; w_done = 0;
        ar_wait = pick(cfg_ar); r_wait = pick(cfg_r);
        aw_wait = pick(cfg_aw); w_wait = pick(cfg_w); b_wait = pick(cfg_b);
    endtask

    task automatic one_cycle();
        bit win_d, i_acc, d_acc, was_busy;
        @(negedge clk);
        cyc++;
        i_pulses += int'(i_rsp_valid);
        d_pulses += int'(d_rsp_valid);

        // Registered outputs, compared against the model state after the last edge.
        if (rsp_exp) begin
            check("i_rsp_valid", i_rsp_valid, !rsp_exp_d);
            check("d_rsp_valid", d_rsp_valid, rsp_exp_d);
            if (rsp_exp_d) begin
                check("d_rsp_rdata", d_rsp_rdata, rsp_exp_data);
                check("d_rsp_err", d_rsp_err, rsp_exp_err);
            end else begin
                check("i_rsp_data", i_rsp_data, rsp_exp_data);
                check("i_rsp_err", i_rsp_err, rsp_exp_err);
            end
            rsp_exp = 0;
        end else begin
            check("no_rsp", {i_rsp_valid, d_rsp_valid}, 32'h0);
        end
        check("arvalid", m_axi_arvalid, busy && !cur.we && !ar_done);
        check("rready",  m_axi_rready,  busy && !cur.we && ar_done);
        check("awvalid", m_axi_awvalid, busy && cur.we && !aw_done);
        check("wvalid",  m_axi_wvalid,  busy && cur.we && !w_done);
        check("bready",  m_axi_bready,  busy && cur.we && aw_done && w_done);
        check("prot", {m_axi_awprot, m_axi_arprot}, 32'h0);
        if (m_axi_arvalid) check("araddr", m_axi_araddr, cur.addr);
        if (m_axi_awvalid) check("awaddr", m_axi_awaddr, cur.addr);
        if (m_axi_wvalid) begin
            check("wdata", m_axi_wdata, cur.wdata);
            check("wstrb", m_axi_wstrb, cur.wstrb);
        end

        // Requesters: present the queue head and hold it until accepted.
        if (!i_hold && i_q.size() > 0 && $urandom_range(99, 0) < pres) i_hold = 1;
        if (!d_hold && d_q.size() > 0 && $urandom_range(99, 0) < pres) d_hold = 1;
        i_req_valid = i_hold;
        i_req_addr  = i_hold ? i_q[0].addr : 32'h0;
        d_req_valid = d_hold;
        d_req_we    = d_hold ? d_q[0].we : 1'b0;
        d_req_addr  = d_hold ? d_q[0].addr : 32'h0;
        d_req_wdata = d_hold ? d_q[0].wdata : 32'h0;
        d_req_wstrb = d_hold ? d_q[0].wstrb : 4'h0;

        // Slave: ready after a per-transaction delay; idle readies toggle randomly.
        if (busy && !cur.we && !ar_done) begin
            m_axi_arready = (ar_wait == 0);
            if (ar_wait > 0) ar_wait--;
        end else m_axi_arready = 1'($urandom_range(1, 0));
        if (busy && cur.we && !aw_done) begin
            m_axi_awready = (aw_wait == 0);
            if (aw_wait > 0) aw_wait--;
        end else m_axi_awready = 1'($urandom_range(1, 0));
        if (busy && cur.we && !w_done) begin
            m_axi_wready = (w_wait == 0);
            if (w_wait > 0) w_wait--;
        end else m_axi_wready = 1'($urandom_range(1, 0));
        if (busy && !cur.we && ar_done) begin
            if (!m_axi_rvalid) begin
                if (r_wait > 0) r_wait--;
                else begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = fix_rdata_en ? fix_rdata : $urandom;
                    m_axi_rresp  = {pick_err(), 1'b0};
                end
            end
        end else m_axi_rvalid = 0;
        if (busy && cur.we && aw_done && w_done) begin
            if (!m_axi_bvalid) begin
                if (b_wait > 0) b_wait--;
                else begin
                    m_axi_bvalid = 1;
                    m_axi_bresp  = {pick_err(), 1'b0};
                end
            end
        end else m_axi_bvalid = 0;

        #1;
        // Arbitration rule: D wins a tie unless it was granted last.
        win_d = d_req_valid && (!i_req_valid || !last_d);
        check("i_req_ready", i_req_ready, !busy && i_req_valid && !win_d);
        check("d_req_ready", d_req_ready, !busy && win_d);
        i_acc = i_req_valid && i_req_ready;
        d_acc = d_req_valid && d_req_ready;

        was_busy = busy;
        if (was_busy) begin
            if (m_axi_arvalid && m_axi_arready) ar_done = 1;
            if (m_axi_awvalid && m_axi_awready) aw_done = 1;
            if (m_axi_wvalid && m_axi_wready) w_done = 1;
            if (m_axi_rvalid && m_axi_rready) begin
                rsp_exp = 1; rsp_exp_d = own_d;
                rsp_exp_data = m_axi_rdata; rsp_exp_err = m_axi_rresp[1];
                busy = 0;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                rsp_exp = 1; rsp_exp_d = 1;
                rsp_exp_data = 32'h0; rsp_exp_err = m_axi_bresp[1];
                busy = 0;
            end
        end else if (d_acc) accept(1'b1);
        else if (i_acc) accept(1'b0);
    endtask

    task automatic run_all(input string tag, input int budget);
        int n = 0;
        while ((i_q.size() > 0 || d_q.size() > 0 || busy || rsp_exp) && n < budget) begin
            one_cycle();
            n++;
        end
        check({tag, "_completed"}, 32'(n < budget), 32'h1);
    endtask

    initial begin
        int n;
        int fp_i, fp_d, fp_irsp;
        cyc = 0;
        zero_inputs();
        clear_model();
        set_cfg(-1, -1, -1, -1, -1, -1, 60);
        #2;
        apply_reset("reset_state");

        // Single fetch: arready at once, rvalid two cycles after the AR handshake.
        set_cfg(0, 2, 0, 0, 0, 0, 100);
        fix_rdata_en = 1'b1; fix_rdata = 32'h0000_0013;
        i_pulses = 0; d_pulses = 0;
        i_q.push_back(rd_req(32'h0000_0100));
        run_all("single_fetch", 40);
        one_cycle();
        check("single_fetch_i_pulses", i_pulses, 1);
        check("single_fetch_d_pulses", d_pulses, 0);
        check("single_fetch_data", i_rsp_data, 32'h0000_0013);

        // Four back-to-back ties: D, I, D, I.
        set_cfg(0, 0, 0, 0, 0, 0, 100);
        grants.delete();
        repeat (2) begin
            i_q.push_back(rand_req(1'b0));
            d_q.push_back(rd_req($urandom & 32'hffff_fffc));
        end
        run_all("tie", 60);
        check("tie_count", grants.size(), 4);
        if (grants.size() == 4) check("tie_order", {grants[0], grants[1], grants[2], grants[3]}, 32'hA);

        // Write: wready three cycles ahead of awready, SLVERR on B.
        set_cfg(0, 0, 3, 0, 1, 1, 100);
        d_pulses = 0;
        d_q.push_back('{we: 1'b1, addr: 32'h0000_2000, wdata: 32'hDEAD_BEEF, wstrb: 4'hF});
        run_all("write", 40);
        one_cycle();
        check("write_d_pulses", d_pulses, 1);
        check("write_err", d_rsp_err, 1);

        // AR stall for five cycles with the fetch port still requesting.
        set_cfg(5, 1, 0, 0, 0, 0, 100);
        i_q.push_back(rd_req(32'h0000_0440));
        i_q.push_back(rd_req(32'h0000_0444));
        run_all("ar_stall", 60);

        // Reset pulse while waiting in the read-data phase.
        set_cfg(0, 12, 0, 0, 0, 0, 100);
        i_q.push_back(rd_req(32'h0000_0300));
        n = 0;
        while (!(busy && ar_done) && n < 20) begin one_cycle(); n++; end
        one_cycle();
        check("mid_read_rready", m_axi_rready, 1);
        #2;
        apply_reset("async_reset");
        i_pulses = 0; d_pulses = 0;
        repeat (4) one_cycle();
        check("reset_no_pulse", i_pulses + d_pulses, 0);
        set_cfg(1, 1, 0, 0, 0, 0, 100);
        d_pulses = 0;
        d_q.push_back(rd_req(32'h0000_0500));
        run_all("post_reset_read", 40);
        one_cycle();
        check("post_reset_d_pulses", d_pulses, 1);

        // Randomised mix across both ports.
        set_cfg(-1, -1, -1, -1, -1, -1, 50);
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(1, 0) != 0) i_q.push_back(rand_req(1'b0));
            else d_q.push_back(rand_req(1'b1));
        end
        run_all("random", 3000);

        // Fixed priority with both ports permanently requesting.
        fp_i = 0; fp_d = 0; fp_irsp = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            f_rvalid = f_rready;
            fp_irsp += int'(f_i_rsp_valid);
            #1;
            fp_i += int'(f_i_req_ready);
            fp_d += int'(f_d_req_ready);
        end
        check("fp_i_grants", fp_i, 0);
        check("fp_d_grants_enough", 32'(fp_d >= 12), 32'h1);
        check("fp_i_rsp", fp_irsp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
